// File: rtl/instr_encoder_pkg.sv
// Instruction-format definitions shared by the encoder and its bench:
// opcodes, condition codes, field bundle, FSM states and the word packer.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  localparam logic [3:0] COND_AL   = 4'hE;
  localparam logic [3:0] COND_RSVD = 4'hF;

  typedef struct packed {
    logic [3:0]  cond;
    op_e         op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
  } fields_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } enc_state_t;

  // Branches keep only funct[5:4] so the 24-bit offset fits below bit 24.
  function automatic logic [31:0] encode_instr(input fields_t f);
    logic [31:0] word;
    if (f.op == OP_BR) begin
      word = {f.cond, f.op, f.funct[5:4], f.imm24};
    end else begin
      word = {f.cond, f.op, f.funct, f.rn, f.rd, f.src2};
    end
    return word;
  endfunction

  function automatic logic is_illegal(input fields_t f);
    return (f.op == OP_ILL) || (f.cond == COND_RSVD);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input handshake and imem write port of the instruction encoder.
// master = field source / memory side, slave = encoder.
interface instr_encoder_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [1:0]        in_op;
  logic [5:0]        in_funct;
  logic [3:0]        in_rn;
  logic [3:0]        in_rd;
  logic [11:0]       in_src2;
  logic [23:0]       in_imm24;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_cond, in_op, in_funct, in_rn, in_rd, in_src2, in_imm24, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_fifo.sv
// Small synchronous FIFO buffering encoded words between acceptance and
// the imem write port; head is the oldest stored word.
module instr_encoder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == CNT_W'(0));
  assign head      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// Encodes field sets into instruction words and writes a run of NUM_WORDS
// of them to consecutive imem addresses through a FIFO with backpressure.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 4,
  parameter int NUM_WORDS = 23
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  instr_encoder_if.slave bus,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [7:0]     drop_count
);
  localparam int               CNT_W  = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0] NUM_C  = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(NUM_WORDS - 1);

  enc_state_t        state_q;
  logic [CNT_W-1:0]  accepted_q;
  logic [CNT_W-1:0]  written_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [7:0]        drop_q;

  fields_t           fields_s;
  logic [WIDTH-1:0]  word_s;
  logic [WIDTH-1:0]  head_s;
  logic              illegal_s;
  logic              ready_s;
  logic              accept_s;
  logic              push_s;
  logic              we_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic              start_run_s;

  assign fields_s  = {bus.in_cond, op_e'(bus.in_op), bus.in_funct, bus.in_rn,
                      bus.in_rd, bus.in_src2, bus.in_imm24};
  assign word_s    = WIDTH'(encode_instr(fields_s));
  assign illegal_s = is_illegal(fields_s);

  always_comb begin
    ready_s     = (state_q == RUN) && !full_s && (accepted_q < NUM_C);
    accept_s    = bus.in_valid && ready_s;
    push_s      = accept_s && !illegal_s;
    we_s        = !empty_s && (written_q < NUM_C);
    pop_s       = we_s && bus.mem_ready;
    start_run_s = start && (state_q != RUN);
  end

  instr_encoder_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (word_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Illegal sets are consumed (in_ready was high) but never reach the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      accepted_q <= '0;
      written_q  <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else if (start_run_s) begin
      state_q    <= RUN;
      accepted_q <= '0;
      written_q  <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 8'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept_s) begin
            if (illegal_s) begin
              err_q <= 1'b1;
              if (drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
              end
            end else begin
              accepted_q <= accepted_q + CNT_W'(1);
            end
          end
          if (pop_s) begin
            addr_q    <= addr_q + ADDR_W'(1);
            written_q <= written_q + CNT_W'(1);
            if (written_q == LAST_C) begin
              state_q <= DONE;
            end
          end
        end
        IDLE, DONE: state_q <= state_q;
        default:    state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.mem_we    = we_s;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = head_s;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign err           = err_q;
  assign drop_count    = drop_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encoding, backpressure,
// illegal drops, a full 23-word run and mid-run reset.
module tb_instr_encoder;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  instr_encoder_if #(.WIDTH(32), .ADDR_W(5)) ifc ();

  instr_encoder #(
    .WIDTH(32), .ADDR_W(5), .DEPTH(4), .NUM_WORDS(23)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (ifc),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && ifc.mem_we && ifc.mem_ready) begin
      wr_addr.push_back(ifc.mem_addr);
      wr_data.push_back(ifc.mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] rn, input logic [3:0] rd,
                            input logic [11:0] s2, input logic [23:0] imm);
    ifc.in_cond  = c;
    ifc.in_op    = o;
    ifc.in_funct = f;
    ifc.in_rn    = rn;
    ifc.in_rd    = rd;
    ifc.in_src2  = s2;
    ifc.in_imm24 = imm;
  endtask

  task automatic offer(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] rn, input logic [3:0] rd,
                       input logic [11:0] s2, input logic [23:0] imm);
    int k;
    set_fields(c, o, f, rn, rd, s2, imm);
    ifc.in_valid = 1'b1;
    k = 0;
    while (!ifc.in_ready && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) check("in_ready_timeout", 32'(k), 32'd0);
    tick();
    ifc.in_valid = 1'b0;
  endtask

  // Generated field sets: cond never 4'hF, op cycles DP/MEM/BR.
  task automatic gen_fields(input int i);
    set_fields(4'(i % 14), 2'(i % 3), 6'(i * 5), 4'(i), 4'(i + 3), 12'(i * 37 + 1), 24'(i * 4097 + 3));
  endtask

  function automatic logic [31:0] gen_word(input int i);
    logic [3:0]  c;
    logic [1:0]  o;
    logic [5:0]  f;
    logic [23:0] imm;
    c   = 4'(i % 14);
    o   = 2'(i % 3);
    f   = 6'(i * 5);
    imm = 24'(i * 4097 + 3);
    if (o == 2'b10) return {c, o, f[5:4], imm};
    return {c, o, f, 4'(i), 4'(i + 3), 12'(i * 37 + 1)};
  endfunction

  task automatic offer_gen(input int i);
    offer(4'(i % 14), 2'(i % 3), 6'(i * 5), 4'(i), 4'(i + 3), 12'(i * 37 + 1), 24'(i * 4097 + 3));
  endtask

  task automatic reset_and_start();
    reset = 1'b0;
    start = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.mem_ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (ifc.mem_we && k < 200) begin
      tick();
      k++;
    end
    check("drain_timeout", 32'(k < 200), 32'd1);
  endtask

  initial begin
    int idx;
    logic rdy;
    logic stable_ok;

    reset = 1'b0;
    start = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.mem_ready = 1'b0;
    set_fields(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 12'h000, 24'h000000);
    #12;
    check("rst_mem_we", 32'(ifc.mem_we), 32'd0);
    check("rst_addr", 32'(ifc.mem_addr), 32'd0);
    check("rst_wdata", ifc.mem_wdata, 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);

    // 1: DP word, minimum latency
    reset_and_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready", 32'(ifc.in_ready), 32'd1);
    set_fields(4'hE, 2'b00, 6'b101000, 4'h2, 4'h1, 12'h005, 24'h000000);
    ifc.in_valid = 1'b1;
    tick();
    ifc.in_valid = 1'b0;
    check("t1_mem_we", 32'(ifc.mem_we), 32'd1);
    check("t1_addr", 32'(ifc.mem_addr), 32'd0);
    check("t1_wdata", ifc.mem_wdata, 32'hE2821005);
    tick();
    check("t1_addr_after", 32'(ifc.mem_addr), 32'd1);
    check("t1_we_after", 32'(ifc.mem_we), 32'd0);

    // 2: branch word
    offer(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'hFFFFFE);
    check("t2_mem_we", 32'(ifc.mem_we), 32'd1);
    check("t2_addr", 32'(ifc.mem_addr), 32'd1);
    check("t2_wdata", ifc.mem_wdata, 32'hEAFFFFFE);
    tick();
    check("t2_addr_after", 32'(ifc.mem_addr), 32'd2);
    check("t2_nwrites", 32'(wr_data.size()), 32'd2);

    // 3: backpressure, 6 sets offered while memory stalls for 10 cycles
    reset_and_start();
    ifc.mem_ready = 1'b0;
    idx = 0;
    stable_ok = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (idx < 6) begin
        gen_fields(idx);
        ifc.in_valid = 1'b1;
      end else begin
        ifc.in_valid = 1'b0;
      end
      rdy = ifc.in_ready;
      tick();
      if (rdy && ifc.in_valid) idx++;
      if (idx > 0 && (ifc.mem_we !== 1'b1 || ifc.mem_addr !== 5'd0 || ifc.mem_wdata !== gen_word(0)))
        stable_ok = 1'b0;
    end
    ifc.in_valid = 1'b0;
    check("t3_accepts", 32'(idx), 32'd4);
    check("t3_in_ready_low", 32'(ifc.in_ready), 32'd0);
    check("t3_stable", 32'(stable_ok), 32'd1);
    check("t3_no_write", 32'(wr_data.size()), 32'd0);
    ifc.mem_ready = 1'b1;
    offer_gen(4);
    offer_gen(5);
    drain();
    check("t3_nwrites", 32'(wr_data.size()), 32'd6);
    for (int i = 0; i < wr_data.size(); i++) begin
      check($sformatf("t3_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("t3_data%0d", i), wr_data[i], gen_word(i));
    end

    // 4: illegal op and reserved cond dropped, drop counter saturates
    reset_and_start();
    offer_gen(1);
    check("t4_err_clean", 32'(err), 32'd0);
    offer(4'hE, 2'b11, 6'h3F, 4'h7, 4'h7, 12'hABC, 24'h123456);
    check("t4_err", 32'(err), 32'd1);
    check("t4_drop1", 32'(drop_count), 32'd1);
    offer_gen(2);
    drain();
    check("t4_nwrites", 32'(wr_data.size()), 32'd2);
    for (int i = 0; i < wr_data.size(); i++) begin
      check($sformatf("t4_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("t4_data%0d", i), wr_data[i], gen_word(i + 1));
    end
    offer(4'hF, 2'b00, 6'h01, 4'h1, 4'h1, 12'h001, 24'h000001);
    check("t4_drop2", 32'(drop_count), 32'd2);
    set_fields(4'hE, 2'b11, 6'h00, 4'h0, 4'h0, 12'h000, 24'h000000);
    ifc.in_valid = 1'b1;
    repeat (260) tick();
    ifc.in_valid = 1'b0;
    check("t4_drop_sat", 32'(drop_count), 32'd255);
    check("t4_sat_nowrite", 32'(wr_data.size()), 32'd2);

    // 5: full run of 23 words, then DONE and restart
    reset_and_start();
    for (int i = 0; i < 23; i++) offer_gen(i);
    check("t5_not_done_early", 32'(done), 32'd0);
    drain();
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_in_ready", 32'(ifc.in_ready), 32'd0);
    check("t5_nwrites", 32'(wr_data.size()), 32'd23);
    for (int i = 0; i < wr_data.size(); i++) begin
      check($sformatf("t5_addr%0d", i), 32'(wr_addr[i]), 32'(i));
      check($sformatf("t5_data%0d", i), wr_data[i], gen_word(i));
    end
    gen_fields(23);
    ifc.in_valid = 1'b1;
    repeat (3) tick();
    ifc.in_valid = 1'b0;
    check("t5_no_extra", 32'(wr_data.size()), 32'd23);
    check("t5_in_ready_hold", 32'(ifc.in_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_busy", 32'(busy), 32'd1);
    check("t5_restart_addr", 32'(ifc.mem_addr), 32'd0);

    // 6: reset mid-run with 3 words buffered
    reset_and_start();
    offer_gen(3);
    tick();
    ifc.mem_ready = 1'b0;
    offer_gen(4);
    offer_gen(5);
    offer_gen(6);
    check("t6_we_buffered", 32'(ifc.mem_we), 32'd1);
    check("t6_addr_pre", 32'(ifc.mem_addr), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_we_async", 32'(ifc.mem_we), 32'd0);
    check("t6_addr_async", 32'(ifc.mem_addr), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    ifc.mem_ready = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    offer_gen(7);
    drain();
    check("t6_nwrites", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() > 0) begin
      check("t6_addr0", 32'(wr_addr[0]), 32'd0);
      check("t6_data0", wr_data[0], gen_word(7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
